// File: rtl/lfu_pkg.sv
// Shared types for the LFU access generator: access codes, FSM states and a
// one-hot decode helper.
package lfu_pkg;

    localparam int NUM_ITEMS = 5;

    typedef enum logic [2:0] {
        ACC_NONE = 3'd0,
        ACC_B1   = 3'd1,
        ACC_B2   = 3'd2,
        ACC_B3   = 3'd3,
        ACC_B4   = 3'd4,
        ACC_B5   = 3'd5
    } acc_code_t;

    typedef enum logic [2:0] {
        IDLE,
        WARM,
        PLAY,
        GAP,
        DONE
    } state_t;

    // Codes 6 and 7 fall into the default arm and decode to no access.
    function automatic logic [NUM_ITEMS-1:0] acc_onehot(input logic [2:0] code);
        case (code)
            ACC_B1:  return 5'b00001;
            ACC_B2:  return 5'b00010;
            ACC_B3:  return 5'b00100;
            ACC_B4:  return 5'b01000;
            ACC_B5:  return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lfu_access_mem.sv
// Sequence storage: DEPTH x 3-bit register file, one synchronous write port and
// one asynchronous read port. Not reset, so contents survive rst.
module lfu_access_mem #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [2:0]               wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [2:0]               rdata
);

    logic [2:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lfu_access_gen.sv
// Plays a stored sequence of one-hot access pulses onto b1..b5 after a warm-up
// delay. Define LFU_ACCESS_GEN_LOOP_EN to replay the sequence endlessly.
module lfu_access_gen
    import lfu_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WARM_CYCLES = 100000000,
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [2:0]               wr_data,
    input  logic [$clog2(DEPTH):0]   len,
    input  logic                     start,
    output logic                     b1,
    output logic                     b2,
    output logic                     b3,
    output logic                     b4,
    output logic                     b5,
    output logic                     busy,
    output logic                     done
);

    localparam int AW      = $clog2(DEPTH);
    localparam int PW      = AW + 1;
    localparam int CNT_MAX = max3(WARM_CYCLES, HOLD_CYCLES, GAP_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t                 state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic [PW-1:0]          ptr, ptr_nx, ptr_inc;
    logic [PW-1:0]          len_q, len_nx, len_sat;
    logic [NUM_ITEMS-1:0]   lines;
    logic [2:0]             rd_code;
    logic                   step;
    logic                   mem_we;

    assign mem_we  = wr_en && (state == IDLE || state == DONE);
    assign len_sat = (len > PW'(DEPTH)) ? PW'(DEPTH) : len;
    assign ptr_inc = ptr + PW'(1);

    lfu_access_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (ptr[AW-1:0]),
        .rdata (rd_code)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        len_nx   = len_q;
        step     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len_sat == '0) begin
                        state_nx = DONE;
                    end else begin
                        len_nx   = len_sat;
                        ptr_nx   = '0;
                        cnt_nx   = '0;
                        state_nx = (WARM_CYCLES == 0) ? PLAY : WARM;
                    end
                end
            end
            WARM: begin
                if (cnt == CW'(WARM_CYCLES - 1)) begin
                    cnt_nx   = '0;
                    state_nx = PLAY;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            PLAY: begin
                if (cnt == CW'(HOLD_CYCLES - 1)) begin
                    cnt_nx = '0;
                    if (GAP_CYCLES > 0) begin
                        state_nx = GAP;
                    end else begin
                        step = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == CW'(GAP_CYCLES - 1)) begin
                    cnt_nx = '0;
                    step   = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Advance to the next entry, or wrap/finish after the last one.
        if (step) begin
            if (ptr_inc == len_q) begin
                ptr_nx = '0;
`ifdef LFU_ACCESS_GEN_LOOP_EN
                state_nx = PLAY;
`else
                state_nx = DONE;
`endif
            end else begin
                ptr_nx   = ptr_inc;
                state_nx = PLAY;
            end
        end
    end

    // Outputs are registered from the current state, so every output trails
    // the state by one cycle; this gives the WARM_CYCLES+1 start-to-line latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            len_q <= '0;
            lines <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ptr   <= ptr_nx;
            len_q <= len_nx;
            lines <= (state == PLAY) ? acc_onehot(rd_code) : '0;
            busy  <= (state == WARM) || (state == PLAY) || (state == GAP);
            done  <= (state == DONE);
        end
    end

    assign b1 = lines[0];
    assign b2 = lines[1];
    assign b3 = lines[2];
    assign b4 = lines[3];
    assign b5 = lines[4];

endmodule

// File: tb/tb_lfu_access_gen.sv
// Randomized self-checking bench for lfu_access_gen (default single-pass build)
// against a per-cycle timeline model of the expected outputs.
module tb_lfu_access_gen;

    localparam int DEPTH = 16;
    localparam int WARM  = 4;
    localparam int HOLD  = 2;
    localparam int GAP   = 1;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;
    logic [AW:0]   len;
    logic          start;
    logic          b1, b2, b3, b4, b5;
    logic          busy;
    logic          done;

    lfu_access_gen #(
        .DEPTH       (DEPTH),
        .WARM_CYCLES (WARM),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .len     (len),
        .start   (start),
        .b1      (b1),
        .b2      (b2),
        .b3      (b3),
        .b4      (b4),
        .b5      (b5),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks;
    int         n_errors;
    logic [2:0] ref_mem [DEPTH];
    logic [6:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] obs();
        return {busy, done, b5, b4, b3, b2, b1};
    endfunction

    // Expected {busy, done, b5..b1} per sample, one sample per cycle starting
    // with the cycle in which start is sampled.
    task automatic build_exp(input int n_req);
        int         n;
        logic [4:0] line;
        n = (n_req > DEPTH) ? DEPTH : n_req;
        exp_q.delete();
        exp_q.push_back(7'b0000000);
        if (n == 0) begin
            exp_q.push_back(7'b0100000);
        end else begin
            repeat (WARM) exp_q.push_back(7'b1000000);
            for (int e = 0; e < n; e++) begin
                line = (ref_mem[e] >= 3'd1 && ref_mem[e] <= 3'd5) ? 5'(1 << (ref_mem[e] - 1)) : 5'b0;
                repeat (HOLD) exp_q.push_back({2'b10, line});
                repeat (GAP)  exp_q.push_back(7'b1000000);
            end
            exp_q.push_back(7'b0100000);
        end
        exp_q.push_back(7'b0000000);
    endtask

    task automatic write_entry(input int addr, input logic [2:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        ref_mem[addr] = data;
    endtask

    // Starts playback at the current negedge and checks every cycle; with
    // stop_at >= 0 it returns right after checking that sample index.
    task automatic play(input int n_req, input bit interfere, input int stop_at);
        build_exp(n_req);
        start = 1'b1;
        len   = (AW+1)'(n_req);
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            chk("trace", 32'(obs()), 32'(exp_q[j]));
            chk("onehot", 32'($onehot0({b1, b2, b3, b4, b5})), 32'd1);
            if (j == stop_at) return;
            if (interfere && (j + 1 < exp_q.size()) && exp_q[j+1][6] && ($urandom_range(1, 0) == 1)) begin
                start   = 1'b1;
                len     = (AW+1)'($urandom_range(DEPTH, 1));
                wr_en   = 1'b1;
                wr_addr = AW'($urandom);
                wr_data = 3'($urandom);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        len      = '0;
        start    = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_out", 32'(obs()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_out", 32'(obs()), 32'd0);

        // Directed sequence {1,1,2,5}
        write_entry(0, 3'd1);
        write_entry(1, 3'd1);
        write_entry(2, 3'd2);
        write_entry(3, 3'd5);
        play(4, 1'b0, -1);

        // Reset during the first b2 hold cycle
        play(4, 1'b0, 11);
        chk("pre_rst_b2", 32'(b2), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_lines", 32'({b5, b4, b3, b2, b1}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst", 32'(obs()), 32'd0);
        end
        play(4, 1'b0, -1);

        // Start/write while busy, then replay to confirm memory unchanged
        play(4, 1'b1, -1);
        play(4, 1'b0, -1);

        // len = 0
        play(0, 1'b0, -1);

        // Non-access codes {0,7}
        write_entry(0, 3'd0);
        write_entry(1, 3'd7);
        play(2, 1'b0, -1);

        // len above DEPTH saturates
        for (int a = 0; a < DEPTH; a++) write_entry(a, 3'($urandom));
        play(DEPTH + 4, 1'b1, -1);

        for (int it = 0; it < 10; it++) begin
            int nw;
            nw = $urandom_range(DEPTH, 1);
            for (int w = 0; w < nw; w++) write_entry($urandom_range(DEPTH - 1, 0), 3'($urandom));
            play($urandom_range(DEPTH + 1, 0), 1'b1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
